// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants for the RISC-V fetch front end. Holds the
//               end-of-program marker, major opcode values and the fetch
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Dummy instruction placed after the last real instruction of a program
    localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] R_I   = 7'b0110011;
    localparam logic [6:0] I_I   = 7'b0000011;
    localparam logic [6:0] Imm_I = 7'b0010011;
    localparam logic [6:0] S_I   = 7'b0100011;
    localparam logic [6:0] B_I   = 7'b1100011;
    localparam logic [6:0] U_I   = 7'b0110111;
    localparam logic [6:0] J_I   = 7'b1101111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    // Fetch control state: RUN issues reads, HALT waits for a redirect
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with power-of-two depth, synchronous
//               active-low reset and a flush that empties it in one edge.
//               The head entry is presented combinationally from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned        DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;

    // Pointer and occupancy tracking; flush behaves like reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_prefetch
// Description : Instruction fetch stage. Reads a synchronous instruction ROM,
//               buffers {pc, instr} in a prefetch FIFO, hands the head to the
//               core over valid/ready, follows branch redirects and stops
//               fetching once the end-of-program word has been pushed.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_prefetch #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned IMEM_AW    = 10,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] EOF_WORD   = riscv_pkg::EOF_WORD
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               eof,
    output logic [15:0]        fetch_count
);

    import riscv_pkg::*;

    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  rd_pc_q, rd_pc_d;      // byte address of the read in flight
    logic         inflight_q;
    logic         eof_q, eof_d;
    logic [15:0]  fetch_count_q, fetch_count_d;

    logic [DEPTH_LOG2:0] fifo_count;
    logic [DEPTH_LOG2:0] occupancy;
    logic                fifo_empty;
    logic                fifo_full_unused;
    logic [63:0]         fifo_head;
    logic                resp_is_eof;
    logic                issue;
    logic                push;
    logic                pop;
    logic                unused_pc_bits;

    // A response arrives exactly one cycle after each read. Issuing is blocked
    // during a redirect, so the only stale response is the one arriving in the
    // redirect cycle itself, and gating push with redirect discards it.
    assign resp_is_eof = inflight_q && (imem_rdata == EOF_WORD);
    assign push        = inflight_q && !redirect;
    assign pop         = !fifo_empty && instr_ready && !redirect;
    assign occupancy   = fifo_count + {{DEPTH_LOG2{1'b0}}, inflight_q};

    // An EOF response suppresses the read that would otherwise go out alongside it
    assign issue = reset_n && (state_q == RUN) && !redirect && !resp_is_eof
                   && (occupancy < DEPTH_C);

    // Next-state for fetch address, state, eof flag and push counter
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rd_pc_d       = rd_pc_q;
        eof_d         = eof_q;
        fetch_count_d = fetch_count_q;
        if (issue) begin
            rd_pc_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) fetch_count_d = fetch_count_q + 16'd1;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            state_d    = RUN;
            eof_d      = 1'b0;
        end else if (push && resp_is_eof) begin
            state_d = HALT;
            eof_d   = 1'b1;
        end
    end

    // Fetch control registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rd_pc_q       <= RESET_PC;
            inflight_q    <= 1'b0;
            eof_q         <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rd_pc_q       <= rd_pc_d;
            inflight_q    <= issue;
            eof_q         <= eof_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    sync_fifo #(
        .WIDTH      (64),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({rd_pc_q, imem_rdata}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

    assign unused_pc_bits = ^{redirect_pc[1:0], fifo_full_unused};

    assign imem_rd     = issue;
    assign imem_addr   = fetch_pc_q[IMEM_AW+1:2];
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head[31:0];
    assign instr_pc    = fifo_head[63:32];
    assign eof         = eof_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire
